// File: rtl/bus_master_pkg.sv
// Shared definitions for the serial bus master and its slave: state encoding,
// default widths and counter sizing.
package bus_master_pkg;

    localparam int unsigned DEF_N   = 8;
    localparam int unsigned DEF_ADN = 12;
    localparam int unsigned DEF_TMO = 255;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ADDR  = 2'd1,
        S_WDATA = 2'd2,
        S_RDATA = 2'd3
    } state_t;

    // Bit-counter width for a W-bit shift register, never narrower than 1.
    function automatic int unsigned cnt_w(input int unsigned w);
        return (w > 32'd1) ? 32'($clog2(w)) : 32'd1;
    endfunction

endpackage

// File: rtl/bus_master_if.sv
// Host-side request/response signals plus the serial slave link of the bus master.
interface bus_master_if import bus_master_pkg::*; #(
    parameter int unsigned N   = DEF_N,
    parameter int unsigned ADN = DEF_ADN
) ();

    logic           req;
    logic           wr;
    logic [ADN-1:0] addr;
    logic [N-1:0]   wdata;
    logic           busy;
    logic           done;
    logic           err;
    logic [N-1:0]   rdata;
    logic           ready;
    logic           validIn;
    logic           DataIn;
    logic           validOut;
    logic           wren;
    logic           Address;
    logic           DataOut;

    modport master (
        input  req, wr, addr, wdata, ready, validIn, DataIn,
        output busy, done, err, rdata, validOut, wren, Address, DataOut
    );

    modport slave (
        output req, wr, addr, wdata, ready, validIn, DataIn,
        input  busy, done, err, rdata, validOut, wren, Address, DataOut
    );

endinterface

// File: rtl/bus_master_shifter.sv
// Right-shifting PISO/SIPO register with a bit counter; bit 0 is the serial
// output and i_sin enters at the MSB, so words travel LSB first.
module bus_master_shifter import bus_master_pkg::*; #(
    parameter int unsigned W = DEF_N
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         i_load,
    input  logic [W-1:0] i_pdata,
    input  logic         i_shift,
    input  logic         i_sin,
    output logic [W-1:0] o_pdata,
    output logic         o_last_c
);

    localparam int unsigned CW = cnt_w(W);

    logic [W-1:0]  r_data;
    logic [CW-1:0] r_cnt;

    // Counter returns to zero on the final shift so it never wraps.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_data <= '0;
            r_cnt  <= '0;
        end else if (i_load) begin
            r_data <= i_pdata;
            r_cnt  <= '0;
        end else if (i_shift) begin
            r_data <= {i_sin, r_data[W-1:1]};
            r_cnt  <= o_last_c ? '0 : r_cnt + CW'(1);
        end
    end

    assign o_pdata  = r_data;
    assign o_last_c = (r_cnt == CW'(W - 1));

endmodule

// File: rtl/bus_master.sv
// Serial bus master: sends address (and write data) LSB first to a slave and
// collects serial read data, with a read-response timeout.
module bus_master import bus_master_pkg::*; #(
    parameter int unsigned N   = DEF_N,
    parameter int unsigned ADN = DEF_ADN,
    parameter int unsigned TMO = DEF_TMO
) (
    input  logic          clk,
    input  logic          rstn,
    bus_master_if.master  bus
);

    localparam int unsigned TW = $clog2(TMO + 1);

    state_t         r_state;
    state_t         w_next_state;
    logic           r_wr;
    logic           r_done;
    logic           r_err;
    logic [N-1:0]   r_rdata;
    logic [TW-1:0]  r_tmo;

    logic           w_accept;
    logic           w_rd_entry;
    logic           w_addr_last;
    logic           w_wdat_last;
    logic           w_rdat_last;
    logic           w_rdat_shift;
    logic           w_rd_done;
    logic           w_wr_done;
    logic           w_timeout;
    logic [ADN-1:0] w_addr_pdata;
    logic [N-1:0]   w_wdat_pdata;
    logic [N-1:0]   w_rdat_pdata;
    logic           w_unused;

    assign w_accept     = (r_state == S_IDLE) && bus.req && bus.ready;
    assign w_rd_entry   = (r_state == S_ADDR) && w_addr_last && !r_wr;
    assign w_rdat_shift = (r_state == S_RDATA) && bus.validIn;
    assign w_rd_done    = w_rdat_shift && w_rdat_last;
    assign w_wr_done    = (r_state == S_WDATA) && w_wdat_last;
    assign w_timeout    = (r_state == S_RDATA) && !bus.validIn && (r_tmo == TW'(TMO - 1));
    assign w_unused     = ^{w_addr_pdata[ADN-1:1], w_wdat_pdata[N-1:1], w_rdat_pdata[0]};

    bus_master_shifter #(.W(ADN)) u_addr_sh (
        .clk      (clk),
        .rstn     (rstn),
        .i_load   (w_accept),
        .i_pdata  (bus.addr),
        .i_shift  (r_state == S_ADDR),
        .i_sin    (1'b0),
        .o_pdata  (w_addr_pdata),
        .o_last_c (w_addr_last)
    );

    bus_master_shifter #(.W(N)) u_wdat_sh (
        .clk      (clk),
        .rstn     (rstn),
        .i_load   (w_accept),
        .i_pdata  (bus.wdata),
        .i_shift  (r_state == S_WDATA),
        .i_sin    (1'b0),
        .o_pdata  (w_wdat_pdata),
        .o_last_c (w_wdat_last)
    );

    // Cleared on RDATA entry so a timed-out partial word never leaks into the next read.
    bus_master_shifter #(.W(N)) u_rdat_sh (
        .clk      (clk),
        .rstn     (rstn),
        .i_load   (w_rd_entry),
        .i_pdata  ('0),
        .i_shift  (w_rdat_shift),
        .i_sin    (bus.DataIn),
        .o_pdata  (w_rdat_pdata),
        .o_last_c (w_rdat_last)
    );

    always_ff @(posedge clk) begin
        if (!rstn) r_state <= S_IDLE;
        else       r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (w_accept)                w_next_state = S_ADDR;
            S_ADDR:  if (w_addr_last)             w_next_state = r_wr ? S_WDATA : S_RDATA;
            S_WDATA: if (w_wdat_last)             w_next_state = S_IDLE;
            S_RDATA: if (w_rd_done || w_timeout)  w_next_state = S_IDLE;
            default:                              w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        bus.busy     = 1'b0;
        bus.validOut = 1'b0;
        bus.wren     = 1'b0;
        bus.Address  = 1'b0;
        bus.DataOut  = 1'b0;
        case (r_state)
            S_ADDR: begin
                bus.busy     = 1'b1;
                bus.validOut = 1'b1;
                bus.wren     = r_wr;
                bus.Address  = w_addr_pdata[0];
            end
            S_WDATA: begin
                bus.busy     = 1'b1;
                bus.validOut = 1'b1;
                bus.wren     = 1'b1;
                bus.DataOut  = w_wdat_pdata[0];
            end
            S_RDATA: bus.busy = 1'b1;
            default: ;
        endcase
    end

    // Completion pulses, latched op, read word and the idle-cycle timeout counter.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_wr    <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_rdata <= '0;
            r_tmo   <= '0;
        end else begin
            r_done <= w_wr_done || w_rd_done;
            r_err  <= w_timeout;
            if (w_accept)  r_wr    <= bus.wr;
            if (w_rd_done) r_rdata <= {bus.DataIn, w_rdat_pdata[N-1:1]};
            if ((r_state != S_RDATA) || bus.validIn) r_tmo <= '0;
            else                                     r_tmo <= r_tmo + TW'(1);
        end
    end

    assign bus.done  = r_done;
    assign bus.err   = r_err;
    assign bus.rdata = r_rdata;

endmodule
